// File: rtl/bfu_data_tape.sv
// bfu_data_tape
//   Data-tape responder for the BFU junction controller. Holds the cell array
//   and the data pointer, answers the controller's data strobes and
//   continuously presents the current cell.
//
//   After reset the tape clears itself, one cell per clock, for TAPELEN
//   cycles. RDY rises once the clear is complete. Strobes that arrive during
//   the clear are ignored and set ERR[0].
//
// Ports
//   CLK   in   1        clock, rising edge
//   RSTN  in   1        asynchronous active-low reset; restarts the clear
//   DSL   in   1        strobe: pointer - 1
//   DSR   in   1        strobe: pointer + 1
//   DT    in   1        strobe: write DI into cell[PTR]
//   DI    in   BITSIZE  write data
//   D     out  BITSIZE  registered copy of cell[PTR]
//   PTR   out  ADDRW    registered data pointer
//   RDY   out  1        1 = idle and accepting strobes, 0 = clearing
//   ERR   out  3        sticky flags: [0] strobe while clearing,
//                       [1] DSL and DSR together, [2] pointer hit a tape end
//
// Configuration macro
//   BFU_TAPE_BOUND_EN  defined: the pointer saturates at both ends and sets
//                      ERR[2]. Undefined: the pointer wraps modulo TAPELEN
//                      and ERR[2] stays 0.
//
// state  | meaning
// CLEAR  | zeroing cell[clr_idx], one cell per clock; strobes ignored
// IDLE   | tape cleared; strobes are serviced
module bfu_data_tape #(
  parameter int BITSIZE = 8,
  parameter int ADDRW   = 10,
  parameter int PTRINIT = 0
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               DSL,
  input  logic               DSR,
  input  logic               DT,
  input  logic [BITSIZE-1:0] DI,
  output logic [BITSIZE-1:0] D,
  output logic [ADDRW-1:0]   PTR,
  output logic               RDY,
  output logic [2:0]         ERR
);

  localparam int TAPELEN = 1 << ADDRW;
  localparam logic [ADDRW-1:0] PTR_RST  = ADDRW'(PTRINIT);
  localparam logic [ADDRW-1:0] ONE      = ADDRW'(1);
  localparam logic [ADDRW-1:0] LAST_IDX = {ADDRW{1'b1}};

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t state, state_nxt;

  logic [ADDRW-1:0]   clr_idx;
  logic [BITSIZE-1:0] cells [TAPELEN];

  logic               strobe_any;
  logic               both_dir;
  logic               mv_l;
  logic               mv_r;
  logic               blk_l;
  logic               blk_r;
  logic               do_move;
  logic [ADDRW-1:0]   ptr_nxt;
  logic               wr_en;
  logic [ADDRW-1:0]   wr_addr;
  logic [BITSIZE-1:0] wr_data;

  // state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // strobe decode
  always_comb begin
    strobe_any = DSL | DSR | DT;
    both_dir   = DSL & DSR;
    mv_l       = DSL & ~DSR;
    mv_r       = DSR & ~DSL;
`ifdef BFU_TAPE_BOUND_EN
    blk_l      = mv_l & (PTR == '0);
    blk_r      = mv_r & (PTR == LAST_IDX);
`else
    blk_l      = 1'b0;
    blk_r      = 1'b0;
`endif
    do_move    = (mv_l & ~blk_l) | (mv_r & ~blk_r);
    // Natural ADDRW-bit overflow gives the modulo-TAPELEN wrap.
    ptr_nxt    = mv_l ? (PTR - ONE) : (PTR + ONE);
  end

  // Single write port, shared by the clear sweep and DT. With a move in the
  // same cycle the write still targets the old pointer.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = PTR;
    wr_data = DI;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
      wr_data = '0;
    end else begin
      wr_en   = DT;
    end
  end

  // Cell array: no reset so it maps onto LUT RAM; the clear sweep zeroes it.
  always_ff @(posedge CLK) begin
    if (wr_en) cells[wr_addr] <= wr_data;
  end

  // datapath registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      D       <= '0;
      PTR     <= PTR_RST;
      RDY     <= 1'b0;
      ERR     <= '0;
      clr_idx <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + ONE;
          PTR     <= PTR_RST;
          D       <= '0;
          if (clr_idx == LAST_IDX) RDY <= 1'b1;
          if (strobe_any)          ERR[0] <= 1'b1;
        end
        ST_IDLE: begin
          if (both_dir)      ERR[1] <= 1'b1;
          if (blk_l | blk_r) ERR[2] <= 1'b1;
          if (do_move) begin
            // The async read sees the pre-edge array, and the new pointer
            // never equals the write address, so no bypass is needed.
            PTR <= ptr_nxt;
            D   <= cells[ptr_nxt];
          end else if (DT && !DSL && !DSR) begin
            D   <= DI;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfu_data_tape.sv
module tb_bfu_data_tape;

  localparam int BITSIZE = 8;
  localparam int ADDRW   = 4;
  localparam int TAPELEN = 16;

  logic               clk_sys;
  logic               rst_n;
  logic               dsl;
  logic               dsr;
  logic               dt;
  logic [BITSIZE-1:0] di;
  logic [BITSIZE-1:0] d;
  logic [ADDRW-1:0]   ptr;
  logic               rdy;
  logic [2:0]         err;

  int n_checks = 0;
  int n_errors = 0;

  bfu_data_tape #(
    .BITSIZE(BITSIZE),
    .ADDRW  (ADDRW),
    .PTRINIT(0)
  ) dut (
    .CLK (clk_sys),
    .RSTN(rst_n),
    .DSL (dsl),
    .DSR (dsr),
    .DT  (dt),
    .DI  (di),
    .D   (d),
    .PTR (ptr),
    .RDY (rdy),
    .ERR (err)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One-cycle strobe pulse, sampled on the next rising edge.
  task automatic pulse(input logic l, input logic r, input logic t, input logic [7:0] val);
    dsl = l;
    dsr = r;
    dt  = t;
    di  = val;
    tick();
    dsl = 1'b0;
    dsr = 1'b0;
    dt  = 1'b0;
    di  = '0;
  endtask

  // Counts rising edges from now until RDY rises, bounded.
  task automatic wait_rdy(output int edges);
    edges = 0;
    while (!rdy && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  int edges;
  int bad;

  initial begin
    rst_n = 1'b0;
    dsl   = 1'b0;
    dsr   = 1'b0;
    dt    = 1'b0;
    di    = '0;
    #12;
    chk("rst_rdy", 32'(rdy), 0);
    chk("rst_d",   32'(d),   0);
    chk("rst_ptr", 32'(ptr), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    rst_n = 1'b1;

    // 1: clear length and all-zero tape, wrap after 16 DSR
    wait_rdy(edges);
    chk("clear_len", 32'(edges), TAPELEN);
    chk("clear_err", 32'(err), 0);
    chk("clear_ptr", 32'(ptr), 0);
    bad = 0;
    for (int i = 0; i < TAPELEN; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      if (d !== 8'h00) bad++;
      if (ptr !== 4'((i + 1) % TAPELEN)) bad++;
    end
    chk("sweep_bad", 32'(bad), 0);
    chk("sweep_wrap_ptr", 32'(ptr), 0);

    // 2: write at 0, step right and back
    pulse(1'b0, 1'b0, 1'b1, 8'h2A);
    chk("t2_wr_d", 32'(d), 32'h2A);
    chk("t2_wr_ptr", 32'(ptr), 0);
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t2_dsr_d", 32'(d), 0);
    chk("t2_dsr_ptr", 32'(ptr), 1);
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t2_dsl_d", 32'(d), 32'h2A);
    chk("t2_dsl_ptr", 32'(ptr), 0);

    // 3: DT + DSR at ptr 3 writes old cell, D shows new cell
    repeat (3) pulse(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t3_ptr3", 32'(ptr), 3);
    pulse(1'b0, 1'b1, 1'b1, 8'h55);
    chk("t3_ptr", 32'(ptr), 4);
    chk("t3_d", 32'(d), 0);
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t3_back_d", 32'(d), 32'h55);
    chk("t3_back_ptr", 32'(ptr), 3);

    // 4: DSL + DSR + DT at ptr 5
    repeat (2) pulse(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t4_ptr5", 32'(ptr), 5);
    pulse(1'b1, 1'b1, 1'b1, 8'h77);
    chk("t4_ptr", 32'(ptr), 5);
    chk("t4_d", 32'(d), 0);
    chk("t4_err", 32'(err), 3'b010);
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t4_written", 32'(d), 32'h77);

    // 6: DSL at pointer 0
    repeat (5) pulse(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t6_ptr0", 32'(ptr), 0);
    chk("t6_d0", 32'(d), 32'h2A);
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef BFU_TAPE_BOUND_EN
    chk("t6_ptr", 32'(ptr), 0);
    chk("t6_d", 32'(d), 32'h2A);
    chk("t6_err", 32'(err), 3'b110);
`else
    chk("t6_ptr", 32'(ptr), TAPELEN - 1);
    chk("t6_d", 32'(d), 0);
    chk("t6_err", 32'(err), 3'b010);
`endif

    // 5: strobe during clear, then reset mid-clear
    rst_n = 1'b0;
    #2;
    chk("t5_rst_d", 32'(d), 0);
    chk("t5_rst_err", 32'(err), 0);
    chk("t5_rst_rdy", 32'(rdy), 0);
    rst_n = 1'b1;
    tick();
    tick();
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t5_ign_ptr", 32'(ptr), 0);
    chk("t5_ign_err", 32'(err), 3'b001);
    chk("t5_ign_rdy", 32'(rdy), 0);
    repeat (5) tick();
    chk("t5_c8_rdy", 32'(rdy), 0);
    rst_n = 1'b0;
    #2;
    chk("t5_mid_err", 32'(err), 0);
    rst_n = 1'b1;
    wait_rdy(edges);
    chk("t5_clear_len", 32'(edges), TAPELEN);
    chk("t5_d0", 32'(d), 0);
    bad = 0;
    for (int i = 0; i < TAPELEN; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      if (d !== 8'h00) bad++;
    end
    chk("t5_sweep_bad", 32'(bad), 0);
    chk("t5_err_end", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
